// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Width of the slice resolved in each pipeline stage.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Input and output valid/ready bundle of pipelined_adder.
// The sub port exists only when PIPE_ADDER_SUB_EN is defined.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PIPE_ADDER_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder built from full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_slice
  import adder_pkg::*;
#(
  parameter int W = slice_w(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SLICE_W-bit slice per stage, carry registered between stages.
// Define PIPE_ADDER_SUB_EN to add the sub port (a-b via inverted B and forced carry-in).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_adder_if.slave  bus
);

  localparam int SLICE_W = slice_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic              in_ready_c;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  // Advance chain resolved from the output back to the input.
  always_comb begin : p_adv
    logic room;
    // NOTE: blocking assignments here on purpose -- 'room' carries the ripple from one
    // stage to the next within the same evaluation; every output gets a value first.
    room = bus.out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = v[k] && room;
      room   = !v[k] || adv[k];
    end
    in_ready_c = room;
  end

  assign bus.in_ready = in_ready_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_W = (k + 1) * SLICE_W;
    localparam int UP_W = WIDTH - LO_W;

    logic [SLICE_W-1:0] sa, sb, ss;
    logic               sci, sco;
    logic               take, fill;
    logic [LO_W-1:0]    s_nxt;
    logic [LO_W-1:0]    s_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_head
      assign sa    = bus.a[SLICE_W-1:0];
      assign sb    = b_eff[SLICE_W-1:0];
      assign sci   = cin_eff;
      assign take  = bus.in_valid && in_ready_c;
      assign s_nxt = ss;
    end else begin : g_body
      assign sa    = g_stage[k-1].g_up.a_up[SLICE_W-1:0];
      assign sb    = g_stage[k-1].g_up.b_up[SLICE_W-1:0];
      assign sci   = g_stage[k-1].c_q;
      assign take  = adv[k-1];
      assign s_nxt = {ss, g_stage[k-1].s_q};
    end

    adder_slice #(.W(SLICE_W)) u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (sci),
      .sum  (ss),
      .cout (sco)
    );

    assign fill = !v_q || adv[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (fill) begin
        v_q <= take;
        if (take) begin
          s_q <= s_nxt;
          c_q <= sco;
        end
      end
    end

    // Unprocessed upper operand bits travel alongside the partial sum.
    if (UP_W > 0) begin : g_up
      logic [UP_W-1:0] a_in, b_in;
      logic [UP_W-1:0] a_up, b_up;

      if (k == 0) begin : g_src
        assign a_in = bus.a[WIDTH-1:SLICE_W];
        assign b_in = b_eff[WIDTH-1:SLICE_W];
      end else begin : g_src
        assign a_in = g_stage[k-1].g_up.a_up[UP_W+SLICE_W-1:SLICE_W];
        assign b_in = g_stage[k-1].g_up.b_up[UP_W+SLICE_W-1:SLICE_W];
      end

      // NOTE: operand registers are not reset -- they are only read behind a set valid
      // bit; sum/carry above are reset because they drive visible outputs.
      always_ff @(posedge clk) begin
        if (fill && take) begin
          a_up <= a_in;
          b_up <= b_in;
        end
      end
    end

    assign v[k] = v_q;
  end

  assign bus.out_valid = v[STAGES-1];
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 32/4 instance with scoreboard, plus an 8/1 instance.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          first_out = -1;
  int          last_out = -1;
  logic        in_fire_s, saw_out;
  logic [32:0] obs_res;
  logic [32:0] exp_q[$];

  // Reference: plain wide arithmetic; for subtraction cout means "no borrow".
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] r;
    if (sub) r = {(a >= b), a - b};
    else     r = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    return r;
  endfunction

  function automatic logic cur_sub();
`ifdef PIPE_ADDER_SUB_EN
    return bus32.sub;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, update the scoreboard at the rising edge.
  task automatic tick();
    logic [32:0] nx;
    logic        rst_s, out_fire;
    @(negedge clk);
    rst_s     = rst;
    in_fire_s = bus32.in_valid && bus32.in_ready && !rst_s;
    out_fire  = bus32.out_valid && bus32.out_ready && !rst_s;
    saw_out   = bus32.out_valid;
    obs_res   = {bus32.cout, bus32.sum};
    nx        = model(bus32.a, bus32.b, bus32.cin, cur_sub());
    if (out_fire) begin
      check("out_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("out_data", {31'b0, obs_res}, {31'b0, exp_q[0]});
        void'(exp_q.pop_front());
      end
      out_cnt++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    @(posedge clk);
    if (rst_s) exp_q.delete();
    else if (in_fire_s) exp_q.push_back(nx);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input logic valid);
    bus32.a        = a;
    bus32.b        = b;
    bus32.cin      = cin;
    bus32.in_valid = valid;
`ifdef PIPE_ADDER_SUB_EN
    bus32.sub      = sub;
`else
    if (sub) bus32.cin = cin;
`endif
  endtask

  task automatic drive_rand(input logic valid);
    drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), valid);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Accept one operation and wait (bounded) for its result; returns the latency in cycles.
  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output int lat);
    drive(a, b, cin, sub, 1'b1);
    tick();
    check("single_accept", 64'(in_fire_s), 64'd1);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (saw_out) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, accepted;
    logic        have_snap;
    logic [32:0] snap;

    rst = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.cin        = 1'b0;
    bus8.out_ready  = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    bus8.sub        = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state of both instances.
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    check("rst_sum_cout",  64'({bus32.cout, bus32.sum}), 64'd0);
    check("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst8_in_ready",  64'(bus8.in_ready),  64'd1);
    check("rst8_sum_cout",  64'({bus8.cout, bus8.sum}), 64'd0);

    // 1: wrap-around and latency.
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_result", 64'(obs_res), 64'h1_0000_0000);

    // 2: 16 back-to-back random adds at full rate.
    out_cnt = 0;
    first_out = -1;
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1);
      tick();
      check("t2_accept", 64'(in_fire_s), 64'd1);
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drain("t2_drain", 40);
    check("t2_count", 64'(out_cnt), 64'd16);
    check("t2_consecutive", 64'(last_out - first_out + 1), 64'd16);

    // 3: fill under backpressure, hold stable, then accept while full and emitting.
    bus32.out_ready = 1'b0;
    accepted  = 0;
    have_snap = 1'b0;
    snap      = '0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      tick();
      if (in_fire_s) accepted++;
      if (saw_out) begin
        if (have_snap) check("t3_stable", 64'(obs_res), 64'(snap));
        snap      = obs_res;
        have_snap = 1'b1;
      end
    end
    check("t3_accepted", 64'(accepted), 64'd4);
    check("t3_in_ready_full", 64'(bus32.in_ready), 64'd0);
    check("t3_held_valid", 64'(bus32.out_valid), 64'd1);
    bus32.out_ready = 1'b1;
    drive_rand(1'b1);
    tick();
    check("t3_full_accept", 64'(in_fire_s), 64'd1);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drain("t3_drain", 40);

    // Random valid/ready traffic: bubbles, stalls, ordering.
    for (int i = 0; i < 120; i++) begin
      drive_rand(1'($urandom_range(1)));
      bus32.out_ready = 1'($urandom_range(3) != 0);
      tick();
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    drain("rand_drain", 60);

    // 4: reset with three in flight, accept offered during reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    rst = 1'b1;
    drive_rand(1'b1);
    tick();
    rst = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("t4_out_valid", 64'(bus32.out_valid), 64'd0);
    check("t4_in_ready",  64'(bus32.in_ready),  64'd1);
    for (int i = 0; i < 6; i++) tick();
    single(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    check("t4_latency", 64'(lat), 64'd4);
    check("t4_result", 64'(obs_res), 64'h0_2345_6789);

`ifdef PIPE_ADDER_SUB_EN
    // 5: subtraction, borrow and no-borrow; cin is ignored when subtracting.
    single(32'd5, 32'd7, 1'b1, 1'b1, lat);
    check("t5_sub_borrow", 64'(obs_res), 64'h0_FFFF_FFFE);
    single(32'd7, 32'd5, 1'b0, 1'b1, lat);
    check("t5_sub_noborrow", 64'(obs_res), 64'h1_0000_0002);
`endif

    // 6: single-stage 8-bit instance, latency 1.
    bus8.a = 8'h80;
    bus8.b = 8'h80;
    bus8.cin = 1'b1;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check("t6_valid", 64'(bus8.out_valid), 64'd1);
    check("t6_result", 64'({bus8.cout, bus8.sum}), 64'h101);
    bus8.a = 8'hFF;
    bus8.b = 8'h00;
    bus8.cin = 1'b1;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check("t6_wrap", 64'({bus8.cout, bus8.sum}), 64'h100);
    tick();
    check("t6_empty", 64'(bus8.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
